// File: rtl/sparc_boot_pkg.sv
// Shared definitions for the byte-stream boot loader:
// FSM encoding, TARGET codes, default frame sync byte.
package sparc_boot_pkg;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_TARGET  = 4'd1;
    localparam logic [3:0] S_ADDR_HI = 4'd2;
    localparam logic [3:0] S_ADDR_LO = 4'd3;
    localparam logic [3:0] S_LEN_HI  = 4'd4;
    localparam logic [3:0] S_LEN_LO  = 4'd5;
    localparam logic [3:0] S_DATA    = 4'd6;
    localparam logic [3:0] S_CHECK   = 4'd7;
    localparam logic [3:0] S_RUN     = 4'd8;
    localparam logic [3:0] S_ERROR   = 4'd9;

    localparam logic [7:0] TGT_IMEM = 8'd0;
    localparam logic [7:0] TGT_DMEM = 8'd1;
    localparam logic [7:0] TGT_GO   = 8'd2;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    typedef struct packed {
        logic       en;
        logic       dmem;
        logic [7:0] data;
    } wr_req_t;

    // True when [base, base+len) does not fit a 2^aw byte memory.
    function automatic logic range_bad(
        input logic [15:0] base,
        input logic [15:0] len,
        input int unsigned aw
    );
        logic [16:0] sum;
        logic [16:0] size;
        sum  = {1'b0, base} + {1'b0, len};
        size = 17'd1 << aw;
        return (sum > size) || ((base >> aw) != 16'd0);
    endfunction

endpackage

// File: rtl/boot_write_port.sv
// Registered write stage: turns an accepted payload byte into a
// one-cycle imem/dmem strobe with its address and data.
module boot_write_port
    import sparc_boot_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  wr_req_t           req,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              imem_we,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            imem_we   <= 1'b0;
            dmem_we   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'd0;
        end else begin
            imem_we <= req.en & ~req.dmem;
            dmem_we <= req.en & req.dmem;
            if (req.en) begin
                mem_addr  <= req_addr;
                mem_wdata <= req.data;
            end
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Host byte-stream frame parser that loads instruction/data memory
// and releases the processor reset on a GO frame.
module boot_loader
    import sparc_boot_pkg::*;
#(
    parameter int         ADDR_W = 9,
    parameter logic [7:0] SYNC   = SYNC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              error,
    output logic [7:0]        frames_ok
);

    logic [3:0]  state;
    logic [3:0]  state_n;
    logic        tgt_dmem;
    logic [15:0] base;
    logic [15:0] len;
    logic [15:0] idx;
    logic [7:0]  chk;
    logic        accept;
    logic [15:0] len_full;
    wr_req_t     req;
    logic [ADDR_W-1:0] req_addr;

    assign accept   = in_valid & in_ready;
    assign len_full = {len[15:8], in_data};
    assign busy     = (state != S_IDLE) && (state != S_RUN);

    always_comb begin
        state_n = state;
        if (accept) begin
            case (state)
                S_IDLE, S_ERROR: begin
                    if (in_data == SYNC) state_n = S_TARGET;
                end
                S_TARGET: begin
                    if (in_data == TGT_GO)
                        state_n = S_RUN;
                    else if (in_data > TGT_DMEM)
                        state_n = S_ERROR;
                    else
                        state_n = S_ADDR_HI;
                end
                S_ADDR_HI: state_n = S_ADDR_LO;
                S_ADDR_LO: state_n = S_LEN_HI;
                S_LEN_HI:  state_n = S_LEN_LO;
                S_LEN_LO: begin
                    if (range_bad(base, len_full, ADDR_W))
                        state_n = S_ERROR;
                    else if (len_full == 16'd0)
                        state_n = S_CHECK;
                    else
                        state_n = S_DATA;
                end
                S_DATA: begin
                    if (idx == len - 16'd1) state_n = S_CHECK;
                end
                S_CHECK: begin
                    state_n = (in_data == chk) ? S_IDLE : S_ERROR;
                end
                default: state_n = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            cpu_reset <= 1'b1;
            error     <= 1'b0;
            frames_ok <= 8'd0;
            tgt_dmem  <= 1'b0;
            base      <= 16'd0;
            len       <= 16'd0;
            idx       <= 16'd0;
            chk       <= 8'd0;
        end else begin
            state    <= state_n;
            in_ready <= (state_n != S_RUN);
            if (state == S_RUN) cpu_reset <= 1'b0;
            // Any path into ERROR flags the frame; a passing CHECK clears it.
            if (accept && state_n == S_ERROR && state != S_ERROR)
                error <= 1'b1;
            if (accept) begin
                case (state)
                    S_TARGET:  tgt_dmem <= in_data[0];
                    S_ADDR_HI: base[15:8] <= in_data;
                    S_ADDR_LO: base[7:0] <= in_data;
                    S_LEN_HI:  len[15:8] <= in_data;
                    S_LEN_LO: begin
                        len[7:0] <= in_data;
                        idx      <= 16'd0;
                        chk      <= 8'd0;
                    end
                    S_DATA: begin
                        idx <= idx + 16'd1;
                        chk <= chk ^ in_data;
                    end
                    S_CHECK: begin
                        if (in_data == chk) begin
                            error <= 1'b0;
                            if (frames_ok != 8'hFF)
                                frames_ok <= frames_ok + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign req.en   = accept && (state == S_DATA);
    assign req.dmem = tgt_dmem;
    assign req.data = in_data;
    assign req_addr = base[ADDR_W-1:0] + idx[ADDR_W-1:0];

    boot_write_port #(
        .ADDR_W (ADDR_W)
    ) u_wport (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_addr  (req_addr),
        .imem_we   (imem_we),
        .dmem_we   (dmem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata)
    );

endmodule
